// File: rtl/timer_arb_pkg.sv
// Shared types and helpers for the arbitrated delay timer.
// Holds the FSM encoding and the round-robin pick function.
package timer_arb_pkg;

    localparam int DEF_N_REQ = 2;
    localparam int DEF_W     = 4;
    localparam int N_MAX     = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic       valid;
        logic [1:0] idx;
    } pick_t;

    // First set bit at or after (last+1) mod n, wrapping.
    // Walking k downward lets the nearest hit overwrite farther ones.
    function automatic pick_t rr_pick(
        input logic [3:0] req,
        input logic [1:0] last,
        input int         n
    );
        pick_t p;
        int    idx;
        p = '0;
        for (int k = N_MAX; k >= 1; k--) begin
            if (k <= n) begin
                idx = (int'(last) + k) % n;
                if (req[idx[1:0]]) begin
                    p.valid = 1'b1;
                    p.idx   = idx[1:0];
                end
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/timer_arbiter_rr.sv
// Combinational round-robin selector for the shared timer.
// Kept separate so fairness can be checked on its own.
module rr_arbiter
    import timer_arb_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ
) (
    input  logic [N_REQ-1:0] req,
    input  logic [1:0]       last,
    output logic             valid,
    output logic [1:0]       winner
);

    logic [3:0] req_ext;
    pick_t      pick;

    assign req_ext = 4'(req);
    assign pick    = rr_pick(req_ext, last, N_REQ);
    assign valid   = pick.valid;
    assign winner  = pick.idx;

endmodule

// File: rtl/timer_arbiter.sv
// Sequencer granting one shared down-counter to N_REQ requesters.
// Grant, countdown, then a one-cycle done pulse to the owner.
module timer_arbiter
    import timer_arb_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int W     = DEF_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*W-1:0] load_val,
    output logic [N_REQ-1:0]   grant,
    output logic [N_REQ-1:0]   done,
    output logic [W-1:0]       count,
    output logic               busy,
    output logic               tick
);

    if (N_REQ < 2 || N_REQ > N_MAX) begin : g_bad_n_req
        $error("timer_arbiter: N_REQ must be in 2..4");
    end

    state_t           state;
    logic [1:0]       last;
    logic             pick_valid;
    logic [1:0]       winner;
    logic [N_REQ-1:0] win_oh;
    logic [W-1:0]     win_load;
    logic             own_req;

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_rr (
        .req    (req),
        .last   (last),
        .valid  (pick_valid),
        .winner (winner)
    );

    // Decode the winner into a one-hot grant and its delay slice
    always_comb begin
        win_oh   = '0;
        win_load = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (winner == 2'(i)) begin
                win_oh[i] = 1'b1;
                win_load  = load_val[i*W +: W];
            end
        end
    end

    // grant is one-hot on the owner, so this is req[owner]
    assign own_req = |(req & grant);

    // Arbitration FSM with the counter and all outputs registered
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            grant <= '0;
            done  <= '0;
            count <= '0;
            busy  <= 1'b0;
            tick  <= 1'b0;
            last  <= 2'(N_REQ - 1);
        end else begin
            done <= '0;
            tick <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        grant <= win_oh;
                        count <= win_load;
                        last  <= winner;
                        busy  <= 1'b1;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!own_req) begin
                        grant <= '0;
                        count <= '0;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else if (count == '0) begin
                        done  <= grant;
                        tick  <= 1'b1;
                        grant <= '0;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_timer_arbiter.sv
// Scoreboard bench for timer_arbiter (N_REQ=2, W=4).
// Stimulus pushes expected grants/dones; a monitor pops and compares.
module tb_timer_arbiter;

    logic       clk;
    logic       reset;
    logic [1:0] req;
    logic [7:0] load_val;
    logic [1:0] grant;
    logic [1:0] done;
    logic [3:0] count;
    logic       busy;
    logic       tick;

    timer_arbiter #(
        .N_REQ (2),
        .W     (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .load_val (load_val),
        .grant    (grant),
        .done     (done),
        .count    (count),
        .busy     (busy),
        .tick     (tick)
    );

    typedef struct {
        logic [1:0] g;
        logic [3:0] c;
    } gexp_t;

    typedef struct {
        logic [1:0] d;
        int         len;
    } dexp_t;

    gexp_t gq[$];
    dexp_t dq[$];

    int nvec = 0;
    int nerr = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_g(input logic [1:0] g, input logic [3:0] c);
        gexp_t e;
        e.g = g;
        e.c = c;
        gq.push_back(e);
    endtask

    task automatic push_d(input logic [1:0] d, input int len);
        dexp_t e;
        e.d   = d;
        e.len = len;
        dq.push_back(e);
    endtask

    // Monitor: new grant and done pulse are the DUT's output events
    logic [1:0] prev_grant = '0;
    int         glen = 0;
    always @(negedge clk) begin
        gexp_t ge;
        dexp_t de;
        if (grant != 2'b00) begin
            if (prev_grant == 2'b00) begin
                glen = 1;
                if (gq.size() == 0) begin
                    chk("unexpected_grant", int'(grant), 0);
                end else begin
                    ge = gq.pop_front();
                    chk("grant", int'(grant), int'(ge.g));
                    chk("grant_load", int'(count), int'(ge.c));
                    chk("grant_busy", int'(busy), 1);
                end
            end else begin
                glen++;
            end
        end
        if (done != 2'b00) begin
            if (dq.size() == 0) begin
                chk("unexpected_done", int'(done), 0);
            end else begin
                de = dq.pop_front();
                chk("done", int'(done), int'(de.d));
                chk("grant_len", glen, de.len);
                chk("done_tick", int'(tick), 1);
                chk("done_busy", int'(busy), 0);
                chk("done_grant", int'(grant), 0);
                chk("done_count", int'(count), 0);
            end
        end else if (tick) begin
            chk("tick_without_done", int'(tick), 0);
        end
        prev_grant = grant;
    end

    task automatic wait_done(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done == 2'b00 && n < 60);
        if (done == 2'b00) chk({name, "_timeout"}, 0, 1);
    endtask

    task automatic wait_count(input string name, input logic [3:0] c);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(grant != 2'b00 && count == c) && n < 60);
        if (count != c) chk({name, "_timeout"}, int'(count), int'(c));
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #2 reset = 1'b1;
        @(posedge clk);
        #2 reset = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        req      = 2'b00;
        load_val = 8'h00;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;

        // reset state
        @(negedge clk);
        chk("rst_grant", int'(grant), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_tick", int'(tick), 0);

        // single request, delay 3
        load_val[3:0] = 4'd3;
        push_g(2'b01, 4'd3);
        push_d(2'b01, 4);
        req = 2'b01;
        wait_done("single");
        req = 2'b00;
        repeat (2) @(negedge clk);

        // simultaneous requests after reset: 0, 1, then 0 again
        pulse_reset();
        load_val = {4'd2, 4'd1};
        push_g(2'b01, 4'd1);
        push_d(2'b01, 2);
        push_g(2'b10, 4'd2);
        push_d(2'b10, 3);
        push_g(2'b01, 4'd1);
        push_d(2'b01, 2);
        req = 2'b11;
        wait_done("rr_a");
        wait_done("rr_b");
        wait_done("rr_c");
        req = 2'b00;
        repeat (2) @(negedge clk);

        // zero delay on requester 1
        load_val = {4'd0, 4'd0};
        push_g(2'b10, 4'd0);
        push_d(2'b10, 1);
        req = 2'b10;
        wait_done("zero");
        req = 2'b00;
        repeat (2) @(negedge clk);

        // abort at count 10, pending requester 1 takes over
        load_val = {4'd2, 4'd15};
        push_g(2'b01, 4'd15);
        req = 2'b11;
        wait_count("abort", 4'd10);
        req = 2'b10;
        @(negedge clk);
        chk("abort_grant", int'(grant), 0);
        chk("abort_count", int'(count), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_tick", int'(tick), 0);
        chk("abort_busy", int'(busy), 0);
        push_g(2'b10, 4'd2);
        push_d(2'b10, 3);
        wait_done("after_abort");
        req = 2'b00;
        repeat (2) @(negedge clk);

        // load_val change during RUN is ignored
        load_val = {4'd0, 4'd5};
        push_g(2'b01, 4'd5);
        push_d(2'b01, 6);
        req = 2'b01;
        repeat (3) @(negedge clk);
        load_val[3:0] = 4'd15;
        wait_done("load_chg");
        req = 2'b00;
        repeat (2) @(negedge clk);

        // asynchronous reset mid-RUN
        load_val = {4'd0, 4'd7};
        push_g(2'b01, 4'd7);
        req = 2'b01;
        wait_count("mid_rst", 4'd3);
        #2 reset = 1'b1;
        #1;
        chk("arst_grant", int'(grant), 0);
        chk("arst_count", int'(count), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_done", int'(done), 0);
        chk("arst_tick", int'(tick), 0);
        repeat (3) @(negedge clk);
        chk("arst_hold_grant", int'(grant), 0);
        @(posedge clk);
        #2 reset = 1'b0;
        req = 2'b00;
        repeat (3) @(negedge clk);

        chk("gq_empty", gq.size(), 0);
        chk("dq_empty", dq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/timer_arbiter.md
Name: timer_arbiter

Overview:
- Shares one 4-bit down-counting timer between N_REQ requesters.
- Each requester holds a level request together with a delay value.
- The controller grants the timer round-robin, loads the delay, runs the countdown, then pulses a per-requester done.
- Sits beside the mod-16 counter datapath as its sequencer. It replaces free-running counting with on-demand, arbitrated delays.

Parameters:
- N_REQ, 2, number of requesters (2..4)
- W, 4, counter/delay width in bits

Ports:
- clk  input  1  system clock, rising-edge
- reset  input  1  asynchronous, active-high reset
- req  input  N_REQ  level request per requester; held until done or abort
- load_val  input  N_REQ*W  delay per requester; slice i is bits [i*W +: W]; sampled only at grant
- grant  output  N_REQ  one-hot owner of the timer; 0 when idle
- done  output  N_REQ  one-cycle completion pulse to the finished owner
- count  output  W  current timer value
- busy  output  1  high while the FSM is in RUN
- tick  output  1  one-cycle pulse when count reaches 0 in RUN

Behaviour:
- Reset (async, any state): state=IDLE, grant=0, done=0, count=0, busy=0, tick=0, last=N_REQ-1, so requester 0 wins first.
- All outputs are registered. done and tick default to 0 each cycle unless set below.
- FSM has two states, IDLE and RUN.
- IDLE, no req: hold; count holds its last value.
- IDLE, any req bit set: choose the winner w.
  - Search starts at (last+1) mod N_REQ and wraps; w is the first set bit found.
  - At the same edge: grant<=onehot(w), count<=load_val[w], last<=w, busy<=1, state<=RUN.
  - Grant latency is 1 cycle from req seen in IDLE.
- RUN, req[w] still high, count!=0: count<=count-1.
- RUN, req[w] still high, count==0:
  - done<=onehot(w), tick<=1, grant<=0, busy<=0, state<=IDLE.
  - grant is high for exactly L+1 cycles for delay L; done is high in the first cycle after grant drops.
- RUN, req[w] low (abort): grant<=0, busy<=0, state<=IDLE, count<=0, no done, no tick. Abort takes priority over count==0 in the same cycle.
- load_val[w]==0: grant lasts 1 cycle, then done.
- Requests from non-owners during RUN are ignored until IDLE; they are not lost, since req is level.
- A requester still high in the done cycle re-arbitrates normally. Round-robin gives any other pending requester priority. A requester that is alone is regranted; this back-to-back regrant is legal.
- Changes to load_val while granted have no effect.
- Decrement is modulo 2^W, but underflow cannot occur because count==0 exits RUN.
- Reset asserted mid-RUN: immediate return to reset values; no done is issued.
- Illegal N_REQ>4: compile-time error via generate-time check.

Decomposition:
- Shared package timer_arb_pkg:
  - state encoding constants ST_IDLE=1'b0, ST_RUN=1'b1
  - default widths W=4, N_REQ=2
  - function rr_pick(req, last) returning the winner index plus a valid flag
- One sub-module, rr_arbiter:
  - purely combinational round-robin pick from req and last
  - lets the verification engineer check arbitration fairness in isolation
- The FSM, counter register and output registers stay in timer_arbiter.

Test Plan:
- Reset check: hold reset=1, then drop it -> grant=00, done=00, count=0000, busy=0. Re-assert reset mid-RUN at count=0011 -> all outputs zero in the same cycle, with no clock edge needed.
- Single request: req=01, load_val[0]=0011 -> grant=01 one edge later for 4 cycles, count 3,2,1,0, then done=01 and tick=1 for one cycle, busy=0.
- Simultaneous requests after reset: req=11, load_val={0010,0001} -> requester 0 granted first (2 cycles), done=01. With req still 11, requester 1 is granted next (3 cycles), done=10, then requester 0 again.
- Zero delay: req=10, load_val[1]=0000 -> grant=10 for exactly 1 cycle, then done=10, count=0000.
- Abort: req=01, load_val[0]=1111; drop req[0] when count=1010 -> next edge grant=00, count=0000, done=00, tick=0. A pending req[1] is granted on the following edge.
- Load change ignored: change load_val[0] from 0101 to 1111 during RUN -> countdown continues from 0101 unchanged, and done arrives after 6 grant cycles.
